// File: rtl/lc3_mem_responder_if.sv
// Memory-bus bundle between the LC-3 control unit, the memory responder,
// the external synchronous RAM and the keyboard/display devices.
interface lc3_mem_responder_if;
  logic        memEN;
  logic        memWE;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        memR;
  logic        ramEn;
  logic        ramWE;
  logic [15:0] ramAddr;
  logic [15:0] ramWData;
  logic [15:0] ramRData;
  logic [7:0]  kbdData;
  logic        kbdValid;
  logic [7:0]  dispData;
  logic        dispValid;
  logic        dispReady;

  // Environment side: control unit, RAM and devices.
  modport master (
    output memEN, memWE, addr, wdata, ramRData, kbdData, kbdValid, dispReady,
    input  rdata, memR, ramEn, ramWE, ramAddr, ramWData, dispData, dispValid
  );

  // Responder side.
  modport slave (
    input  memEN, memWE, addr, wdata, ramRData, kbdData, kbdValid, dispReady,
    output rdata, memR, ramEn, ramWE, ramAddr, ramWData, dispData, dispValid
  );
endinterface

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: single-outstanding request FSM with optional wait
// states, external synchronous RAM port and keyboard/display MMIO registers.
module lc3_mem_responder #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  lc3_mem_responder_if.slave io_bus
);

  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, RDATA, DONE} state_t;

  localparam logic [6:0]  IO_PAGE   = 7'h7F;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_wait_cnt;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_we;
  logic [15:0] r_rdata;
  logic        r_mem_r;
  logic [7:0]  r_kbd_buf;
  logic        r_kbd_full;
  logic        r_overrun;
  logic [7:0]  r_disp_data;
  logic        r_disp_valid;

  logic        w_is_io;
  logic        w_io_access;
  logic        w_kbd_clr;
  logic        w_ddr_wr;
  logic        w_disp_take;
  logic [15:0] w_io_rdata;

  assign w_is_io     = (r_addr[15:9] == IO_PAGE);
  assign w_io_access = (r_state == ACCESS) && w_is_io;
  assign w_kbd_clr   = w_io_access && !r_we && (r_addr == KBDR_ADDR);
  assign w_ddr_wr    = w_io_access && r_we && (r_addr == DDR_ADDR) && !r_disp_valid;
  assign w_disp_take = r_disp_valid && io_bus.dispReady;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (io_bus.memEN) w_state_next = (WAIT_INIT != 4'd0) ? WAIT : ACCESS;
      WAIT:    if (r_wait_cnt <= 4'd1) w_state_next = ACCESS;
      ACCESS:  w_state_next = (!w_is_io && !r_we) ? RDATA : DONE;
      RDATA:   w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_io_rdata = '0;
    case (r_addr)
      KBSR_ADDR: w_io_rdata = {r_kbd_full, r_overrun, 14'b0};
      KBDR_ADDR: w_io_rdata = {8'h00, r_kbd_buf};
      DSR_ADDR:  w_io_rdata = {~r_disp_valid, 15'b0};
      default:   w_io_rdata = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_rdata    <= '0;
      r_mem_r    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // memR is registered out of DONE, so it rises on the edge leaving DONE.
      r_mem_r <= (r_state == DONE);
      if (r_state == IDLE && io_bus.memEN) begin
        r_addr     <= io_bus.addr;
        r_wdata    <= io_bus.wdata;
        r_we       <= io_bus.memWE;
        r_wait_cnt <= WAIT_INIT;
      end else if (r_state == WAIT) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if (r_state == RDATA) begin
        r_rdata <= io_bus.ramRData;
      end else if (w_io_access && !r_we) begin
        r_rdata <= w_io_rdata;
      end
    end
  end

  // Keyboard and display run independently of the request FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kbd_buf    <= '0;
      r_kbd_full   <= 1'b0;
      r_overrun    <= 1'b0;
      r_disp_data  <= '0;
      r_disp_valid <= 1'b0;
    end else begin
      if (io_bus.kbdValid) begin
        // A KBDR read on the same edge frees the buffer for the new character.
        if (!r_kbd_full || w_kbd_clr) begin
          r_kbd_buf  <= io_bus.kbdData;
          r_kbd_full <= 1'b1;
        end
        r_overrun <= w_kbd_clr ? 1'b0 : (r_overrun | r_kbd_full);
      end else if (w_kbd_clr) begin
        r_kbd_full <= 1'b0;
        r_overrun  <= 1'b0;
      end

      if (w_ddr_wr) begin
        r_disp_data  <= r_wdata[7:0];
        r_disp_valid <= 1'b1;
      end else if (w_disp_take) begin
        r_disp_valid <= 1'b0;
      end
    end
  end

  assign io_bus.rdata     = r_rdata;
  assign io_bus.memR      = r_mem_r;
  assign io_bus.ramEn     = (r_state == ACCESS) && !w_is_io;
  assign io_bus.ramWE     = (r_state == ACCESS) && !w_is_io && r_we;
  assign io_bus.ramAddr   = r_addr;
  assign io_bus.ramWData  = r_wdata;
  assign io_bus.dispData  = r_disp_data;
  assign io_bus.dispValid = r_disp_valid;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench: two responders (0 and 3 wait states) share the request
// stimulus; a scoreboard per instance checks latency and rdata of every memR.
module tb_lc3_mem_responder;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    int          accept;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_we;
  logic [15:0] addr, wdata;
  logic        kv0, kv3;
  logic [7:0]  kd0, kd3;
  logic        disp_ready;
  logic [15:0] ram_rd [2];
  logic [15:0] mem0 [65536];
  logic [15:0] mem3 [65536];
  int          we_cnt [2];
  int          cyc;
  int          checks;
  int          failures;
  logic [15:0] last_rd;
  exp_t        q [2][$];
  vec_t        vecs [15];

  lc3_mem_responder_if bus0 ();
  lc3_mem_responder_if bus3 ();

  lc3_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .io_bus(bus0));
  lc3_mem_responder #(.WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .io_bus(bus3));

  assign bus0.memEN = mem_en;      assign bus3.memEN = mem_en;
  assign bus0.memWE = mem_we;      assign bus3.memWE = mem_we;
  assign bus0.addr = addr;         assign bus3.addr = addr;
  assign bus0.wdata = wdata;       assign bus3.wdata = wdata;
  assign bus0.dispReady = disp_ready;
  assign bus3.dispReady = disp_ready;
  assign bus0.kbdValid = kv0;      assign bus3.kbdValid = kv3;
  assign bus0.kbdData = kd0;       assign bus3.kbdData = kd3;
  assign bus0.ramRData = ram_rd[0];
  assign bus3.ramRData = ram_rd[1];

  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM models: data appears one cycle after a read enable.
  initial begin
    we_cnt[0] = 0;
    we_cnt[1] = 0;
    for (int i = 0; i < 65536; i++) begin
      mem0[i] = 16'h0000;
      mem3[i] = 16'h0000;
    end
    mem0[16'h4000] = 16'hBEEF;  mem3[16'h4000] = 16'hBEEF;
    mem0[16'h5000] = 16'h1111;  mem3[16'h5000] = 16'h1111;
  end

  always @(posedge clk) begin
    if (bus0.ramEn) begin
      if (bus0.ramWE) begin
        mem0[bus0.ramAddr] <= bus0.ramWData;
        we_cnt[0] <= we_cnt[0] + 1;
      end else begin
        ram_rd[0] <= mem0[bus0.ramAddr];
      end
    end
    if (bus3.ramEn) begin
      if (bus3.ramWE) begin
        mem3[bus3.ramAddr] <= bus3.ramWData;
        we_cnt[1] <= we_cnt[1] + 1;
      end else begin
        ram_rd[1] <= mem3[bus3.ramAddr];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic complete(input int d, input logic [15:0] rd);
    exp_t e;
    check($sformatf("memR_expected_dut%0d", d), 64'(q[d].size() != 0), 64'd1);
    if (q[d].size() != 0) begin
      e = q[d].pop_front();
      check($sformatf("latency_dut%0d", d), 64'(cyc - e.accept), 64'(e.lat));
      check($sformatf("rdata_dut%0d", d), 64'(rd), 64'(e.rdata));
    end
  endtask

  // Response monitor and RAM-port sanity, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus0.memR) complete(0, bus0.rdata);
    if (bus3.memR) complete(1, bus3.rdata);
    if (bus0.ramEn) check("ramEn_io_page_dut0", 64'(bus0.ramAddr[15:9] == 7'h7F), 64'd0);
    if (bus3.ramEn) check("ramEn_io_page_dut1", 64'(bus3.ramAddr[15:9] == 7'h7F), 64'd0);
  end

  // Expected result of one accepted request, per the latency rules.
  task automatic push_exp(input logic we, input logic [15:0] a, input logic [15:0] exp_rd);
    exp_t e;
    logic io;
    io = (a[15:9] == 7'h7F);
    if (!we) last_rd = exp_rd;
    e.rdata  = last_rd;
    e.accept = cyc + 1;
    e.lat    = (!we && !io) ? 3 : 2;
    q[0].push_back(e);
    e.lat = e.lat + 3;
    q[1].push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("response_timeout", 64'(q[0].size() + q[1].size()), 64'd0);
    q[0].delete();
    q[1].delete();
  endtask

  task automatic request(input logic we, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] exp_rd);
    int wc0, wc1;
    logic ram_wr;
    ram_wr = we && (a[15:9] != 7'h7F);
    @(negedge clk);
    wc0 = we_cnt[0];
    wc1 = we_cnt[1];
    mem_en = 1'b1; mem_we = we; addr = a; wdata = d;
    push_exp(we, a, exp_rd);
    @(negedge clk);
    mem_en = 1'b0;
    wait_idle();
    check($sformatf("ram_writes_dut0_%h", a), 64'(we_cnt[0] - wc0), 64'(ram_wr));
    check($sformatf("ram_writes_dut1_%h", a), 64'(we_cnt[1] - wc1), 64'(ram_wr));
  endtask

  task automatic kbd_pulse(input logic [7:0] c);
    @(negedge clk);
    kv0 = 1'b1; kv3 = 1'b1; kd0 = c; kd3 = c;
    @(negedge clk);
    kv0 = 1'b0; kv3 = 1'b0;
  endtask

  task automatic check_disp(input string tag, input logic v, input logic [7:0] d);
    check({tag, "_dispValid_dut0"}, 64'(bus0.dispValid), 64'(v));
    check({tag, "_dispValid_dut1"}, 64'(bus3.dispValid), 64'(v));
    check({tag, "_dispData_dut0"}, 64'(bus0.dispData), 64'(d));
    check({tag, "_dispData_dut1"}, 64'(bus3.dispData), 64'(d));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_outputs_dut0"},
          64'({bus0.memR, bus0.ramEn, bus0.ramWE, bus0.ramAddr, bus0.ramWData,
               bus0.rdata, bus0.dispData, bus0.dispValid}), 64'd0);
    check({tag, "_outputs_dut1"},
          64'({bus3.memR, bus3.ramEn, bus3.ramWE, bus3.ramAddr, bus3.ramWData,
               bus3.rdata, bus3.dispData, bus3.dispValid}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int wc0, wc1;
    checks = 0; failures = 0; last_rd = 16'h0000;
    rst = 1'b1; mem_en = 1'b0; mem_we = 1'b0; addr = '0; wdata = '0;
    kv0 = 1'b0; kv3 = 1'b0; kd0 = '0; kd3 = '0; disp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_reset("reset_state");
    rst = 1'b0;

    // we, addr, wdata, expected rdata of a read
    vecs = '{
      '{1'b1, 16'h3000, 16'h1234, 16'h0000},
      '{1'b0, 16'h3000, 16'h0000, 16'h1234},
      '{1'b1, 16'h0000, 16'hA5A5, 16'h0000},
      '{1'b1, 16'hFDFE, 16'h0F0F, 16'h0000},
      '{1'b0, 16'hFDFE, 16'h0000, 16'h0F0F},
      '{1'b0, 16'h0000, 16'h0000, 16'hA5A5},
      '{1'b0, 16'h4000, 16'h0000, 16'hBEEF},
      '{1'b1, 16'hFE08, 16'hFFFF, 16'h0000},
      '{1'b0, 16'hFE08, 16'h0000, 16'h0000},
      '{1'b0, 16'hFFFE, 16'h0000, 16'h0000},
      '{1'b0, 16'hFE00, 16'h0000, 16'h0000},
      '{1'b0, 16'hFE04, 16'h0000, 16'h8000},
      '{1'b0, 16'hFE06, 16'h0000, 16'h0000},
      '{1'b1, 16'hFE00, 16'hFFFF, 16'h0000},
      '{1'b0, 16'hFE00, 16'h0000, 16'h0000}
    };
    for (int i = 0; i < 15; i++) begin
      request(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
    end

    // memEN held through WAIT/ACCESS/RDATA/DONE must not start a second access.
    @(negedge clk);
    mem_en = 1'b1; mem_we = 1'b0; addr = 16'h4000; wdata = 16'h0000;
    push_exp(1'b0, 16'h4000, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_we = 1'b1; addr = 16'h4000; wdata = 16'hDEAD;
    end
    @(negedge clk);
    mem_en = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    request(1'b0, 16'h4000, 16'h0000, 16'hBEEF);

    // Keyboard: single character, then overrun.
    kbd_pulse(8'h41);
    request(1'b0, 16'hFE00, 16'h0000, 16'h8000);
    request(1'b0, 16'hFE02, 16'h0000, 16'h0041);
    request(1'b0, 16'hFE00, 16'h0000, 16'h0000);
    kbd_pulse(8'h10);
    kbd_pulse(8'h11);
    request(1'b0, 16'hFE00, 16'h0000, 16'hC000);
    request(1'b0, 16'hFE02, 16'h0000, 16'h0010);
    request(1'b0, 16'hFE00, 16'h0000, 16'h0000);

    // kbdValid on the exact KBDR-clear edge of each instance.
    kbd_pulse(8'h41);
    @(negedge clk);
    mem_en = 1'b1; mem_we = 1'b0; addr = 16'hFE02;
    push_exp(1'b0, 16'hFE02, 16'h0041);
    @(negedge clk);
    mem_en = 1'b0; kv0 = 1'b1; kd0 = 8'h42;
    @(negedge clk);
    kv0 = 1'b0;
    repeat (2) @(negedge clk);
    kv3 = 1'b1; kd3 = 8'h42;
    @(negedge clk);
    kv3 = 1'b0;
    wait_idle();
    request(1'b0, 16'hFE00, 16'h0000, 16'h8000);
    request(1'b0, 16'hFE02, 16'h0000, 16'h0042);
    request(1'b0, 16'hFE00, 16'h0000, 16'h0000);

    // Display: accept, drop while busy, drain.
    request(1'b1, 16'hFE06, 16'h0058, 16'h0000);
    check_disp("ddr_first", 1'b1, 8'h58);
    request(1'b0, 16'hFE04, 16'h0000, 16'h0000);
    request(1'b1, 16'hFE06, 16'h0059, 16'h0000);
    check_disp("ddr_dropped", 1'b1, 8'h58);
    @(negedge clk);
    disp_ready = 1'b1;
    @(negedge clk);
    disp_ready = 1'b0;
    check_disp("ddr_drained", 1'b0, 8'h58);
    request(1'b0, 16'hFE04, 16'h0000, 16'h8000);

    // Reset during a RAM write (ACCESS for 0 waits, WAIT for 3 waits).
    request(1'b1, 16'hFE06, 16'h005A, 16'h0000);
    kbd_pulse(8'h33);
    request(1'b0, 16'h4000, 16'h0000, 16'hBEEF);
    @(negedge clk);
    wc0 = we_cnt[0];
    wc1 = we_cnt[1];
    mem_en = 1'b1; mem_we = 1'b1; addr = 16'h5000; wdata = 16'h7777;
    @(negedge clk);
    mem_en = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_rd = 16'h0000;
    repeat (10) @(negedge clk);
    check("abort_ram_writes_dut0", 64'(we_cnt[0] - wc0), 64'd0);
    check("abort_ram_writes_dut1", 64'(we_cnt[1] - wc1), 64'd0);
    request(1'b0, 16'h5000, 16'h0000, 16'h1111);
    request(1'b0, 16'hFE00, 16'h0000, 16'h0000);
    request(1'b0, 16'hFE04, 16'h0000, 16'h8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
